issue_select_scheduler: RTL and testbench

ISSUE_SELECT_SCHEDULER -- requirements
Module: issue_select_scheduler

---
 rtl/issue_select_scheduler_pkg.sv | 22 ++
 rtl/issue_select_scheduler_age_matrix_select.sv | 36 +++
 rtl/issue_select_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_issue_select_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_select_scheduler_pkg.sv
// Shared definitions for the issue/select scheduler.
//
// Contents:
//   PRF_W_DEF / OP_W_DEF : default physical-register tag and opcode widths
//   entry_t              : one reservation-station record (valid, opcode,
//                          two source tags with ready bits, destination tag)
package issue_select_scheduler_pkg;

  localparam int PRF_W_DEF = 6;
  localparam int OP_W_DEF  = 5;

  typedef struct packed {
    logic                 valid;
    logic [OP_W_DEF-1:0]  opcode;
    logic [PRF_W_DEF-1:0] src1_prf;
    logic                 src1_rdy;
    logic [PRF_W_DEF-1:0] src2_prf;
    logic                 src2_rdy;
    logic [PRF_W_DEF-1:0] dest_prf;
  } entry_t;

endpackage

// File: rtl/issue_select_scheduler_age_matrix_select.sv
// Oldest-first selection over an age matrix.
//
// Ports:
//   eligible_i  [DEPTH]        entries that may issue this cycle
//   age_i       [DEPTH*DEPTH]  age_i[j*DEPTH+i] = 1 when entry j is older than i
//   grant_o     [DEPTH]        one-hot grant of the oldest eligible entry
//   any_grant_o                at least one entry is eligible
module age_matrix_select #(
  parameter int DEPTH = 8
) (
  input  logic [DEPTH-1:0]       eligible_i,
  input  logic [DEPTH*DEPTH-1:0] age_i,
  output logic [DEPTH-1:0]       grant_o,
  output logic                   any_grant_o
);

  logic [DEPTH-1:0] blocked;

  // An eligible entry wins unless some other eligible entry is older than it.
  // Ages among valid entries form a total order, so exactly one entry wins.
  always_comb begin
    blocked = '0;
    grant_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if ((j != i) && eligible_i[j] && age_i[j*DEPTH+i]) begin
          blocked[i] = 1'b1;
        end
      end
      grant_o[i] = eligible_i[i] && !blocked[i];
    end
  end

  assign any_grant_o = |eligible_i;

endmodule

// File: rtl/issue_select_scheduler.sv
// Out-of-order issue scheduler: a DEPTH-entry reservation station with CDB
// wakeup, age-matrix oldest-first select and a registered issue port.
//
// Ports:
//   clk, reset (async, active low), flush (sync squash)
//   disp_*      dispatch request / payload, disp_ready back-pressure
//   cdb_valid, cdb_tag   result broadcast used for operand wakeup
//   issue_*     registered instruction to the functional unit (valid/ready)
//   occupancy   number of valid entries, not counting the output register
module issue_select_scheduler
  import issue_select_scheduler_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PRF_W = PRF_W_DEF,
  parameter int OP_W  = OP_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [OP_W-1:0]          disp_opcode,
  input  logic [PRF_W-1:0]         disp_src1_prf,
  input  logic [PRF_W-1:0]         disp_src2_prf,
  input  logic [PRF_W-1:0]         disp_dest_prf,
  input  logic                     disp_src1_ready,
  input  logic                     disp_src2_ready,
  input  logic                     cdb_valid,
  input  logic [PRF_W-1:0]         cdb_tag,
  output logic                     issue_valid,
  input  logic                     issue_ready,
  output logic [OP_W-1:0]          issue_opcode,
  output logic [PRF_W-1:0]         issue_src1_prf,
  output logic [PRF_W-1:0]         issue_src2_prf,
  output logic [PRF_W-1:0]         issue_dest_prf,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  // Entry control state
  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [DEPTH-1:0]       rdy1_q, rdy1_d;
  logic [DEPTH-1:0]       rdy2_q, rdy2_d;
  logic [DEPTH*DEPTH-1:0] age_q, age_d;

  // Entry payload (not reset: only meaningful while valid)
  logic [OP_W-1:0]  opcode_q [DEPTH];
  logic [OP_W-1:0]  opcode_d [DEPTH];
  logic [PRF_W-1:0] src1_q   [DEPTH];
  logic [PRF_W-1:0] src1_d   [DEPTH];
  logic [PRF_W-1:0] src2_q   [DEPTH];
  logic [PRF_W-1:0] src2_d   [DEPTH];
  logic [PRF_W-1:0] dest_q   [DEPTH];
  logic [PRF_W-1:0] dest_d   [DEPTH];

  // Output register
  logic             issue_valid_q, issue_valid_d;
  logic [OP_W-1:0]  issue_opcode_q, issue_opcode_d;
  logic [PRF_W-1:0] issue_src1_q, issue_src1_d;
  logic [PRF_W-1:0] issue_src2_q, issue_src2_d;
  logic [PRF_W-1:0] issue_dest_q, issue_dest_d;

  // Combinational helpers
  logic [DEPTH-1:0] hit1, hit2, eligible, grant;
  logic             any_grant;
  logic [CNT_W-1:0] occ;
  logic [IDX_W-1:0] free_idx, sel_idx;
  logic             disp_fire, load_out, disp_hit1, disp_hit2;

  // Per-entry wakeup compare; a CDB match counts as ready in the same cycle
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      hit1[i] = cdb_valid && (cdb_tag == src1_q[i]);
      hit2[i] = cdb_valid && (cdb_tag == src2_q[i]);
    end
  end

  assign eligible = valid_q & (rdy1_q | hit1) & (rdy2_q | hit2);

  age_matrix_select #(
    .DEPTH (DEPTH)
  ) u_select (
    .eligible_i  (eligible),
    .age_i       (age_q),
    .grant_o     (grant),
    .any_grant_o (any_grant)
  );

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant[i]) begin
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + CNT_W'(valid_q[i]);
    end
  end

  // Lowest-index invalid entry; scanning downward leaves the lowest one
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_idx = IDX_W'(i);
      end
    end
  end

  // An entry being selected this cycle is still counted as occupied
  assign disp_ready = (occ < CNT_W'(DEPTH));
  assign disp_fire  = disp_valid && disp_ready;
  assign load_out   = !issue_valid_q || issue_ready;
  assign disp_hit1  = cdb_valid && (cdb_tag == disp_src1_prf);
  assign disp_hit2  = cdb_valid && (cdb_tag == disp_src2_prf);

  always_comb begin
    valid_d        = valid_q;
    rdy1_d         = rdy1_q;
    rdy2_d         = rdy2_q;
    age_d          = age_q;
    opcode_d       = opcode_q;
    src1_d         = src1_q;
    src2_d         = src2_q;
    dest_d         = dest_q;
    issue_valid_d  = issue_valid_q;
    issue_opcode_d = issue_opcode_q;
    issue_src1_d   = issue_src1_q;
    issue_src2_d   = issue_src2_q;
    issue_dest_d   = issue_dest_q;

    if (flush) begin
      valid_d        = '0;
      issue_valid_d  = 1'b0;
      issue_opcode_d = '0;
      issue_src1_d   = '0;
      issue_src2_d   = '0;
      issue_dest_d   = '0;
    end else begin
      rdy1_d = rdy1_q | (hit1 & valid_q);
      rdy2_d = rdy2_q | (hit2 & valid_q);

      if (load_out) begin
        valid_d        = valid_d & ~grant;
        issue_valid_d  = any_grant;
        issue_opcode_d = any_grant ? opcode_q[sel_idx] : '0;
        issue_src1_d   = any_grant ? src1_q[sel_idx]   : '0;
        issue_src2_d   = any_grant ? src2_q[sel_idx]   : '0;
        issue_dest_d   = any_grant ? dest_q[sel_idx]   : '0;
      end

      // The free slot is never the granted slot, so both updates coexist.
      // New entry: older than nobody (row cleared), younger than every
      // currently valid entry (column copied from valid_q).
      if (disp_fire) begin
        valid_d[free_idx]  = 1'b1;
        rdy1_d[free_idx]   = disp_src1_ready || disp_hit1;
        rdy2_d[free_idx]   = disp_src2_ready || disp_hit2;
        opcode_d[free_idx] = disp_opcode;
        src1_d[free_idx]   = disp_src1_prf;
        src2_d[free_idx]   = disp_src2_prf;
        dest_d[free_idx]   = disp_dest_prf;
        for (int j = 0; j < DEPTH; j++) begin
          age_d[int'(free_idx)*DEPTH+j] = 1'b0;
          age_d[j*DEPTH+int'(free_idx)] = valid_q[j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q        <= '0;
      rdy1_q         <= '0;
      rdy2_q         <= '0;
      age_q          <= '0;
      issue_valid_q  <= 1'b0;
      issue_opcode_q <= '0;
      issue_src1_q   <= '0;
      issue_src2_q   <= '0;
      issue_dest_q   <= '0;
    end else begin
      valid_q        <= valid_d;
      rdy1_q         <= rdy1_d;
      rdy2_q         <= rdy2_d;
      age_q          <= age_d;
      issue_valid_q  <= issue_valid_d;
      issue_opcode_q <= issue_opcode_d;
      issue_src1_q   <= issue_src1_d;
      issue_src2_q   <= issue_src2_d;
      issue_dest_q   <= issue_dest_d;
    end
  end

  always_ff @(posedge clk) begin
    opcode_q <= opcode_d;
    src1_q   <= src1_d;
    src2_q   <= src2_d;
    dest_q   <= dest_d;
  end

  assign issue_valid    = issue_valid_q;
  assign issue_opcode   = issue_opcode_q;
  assign issue_src1_prf = issue_src1_q;
  assign issue_src2_prf = issue_src2_q;
  assign issue_dest_prf = issue_dest_q;
  assign occupancy      = occ;

endmodule

// File: tb/tb_issue_select_scheduler.sv
// Self-checking bench for issue_select_scheduler: directed scenarios followed
// by randomized traffic, compared against a queue-based reference model.
module tb_issue_select_scheduler;
  import issue_select_scheduler_pkg::*;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       flush = 1'b0;
  logic       disp_valid = 1'b0;
  logic       disp_ready;
  logic [4:0] disp_opcode = '0;
  logic [5:0] disp_src1_prf = '0, disp_src2_prf = '0, disp_dest_prf = '0;
  logic       disp_src1_ready = 1'b0, disp_src2_ready = 1'b0;
  logic       cdb_valid = 1'b0;
  logic [5:0] cdb_tag = '0;
  logic       issue_valid;
  logic       issue_ready = 1'b1;
  logic [4:0] issue_opcode;
  logic [5:0] issue_src1_prf, issue_src2_prf, issue_dest_prf;
  logic [3:0] occupancy;

  issue_select_scheduler #(.DEPTH(DEPTH), .PRF_W(6), .OP_W(5)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_opcode(disp_opcode), .disp_src1_prf(disp_src1_prf),
    .disp_src2_prf(disp_src2_prf), .disp_dest_prf(disp_dest_prf),
    .disp_src1_ready(disp_src1_ready), .disp_src2_ready(disp_src2_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_opcode(issue_opcode), .issue_src1_prf(issue_src1_prf),
    .issue_src2_prf(issue_src2_prf), .issue_dest_prf(issue_dest_prf),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Expected observable state for one cycle
  typedef struct {
    int cyc;
    int occ;
    bit drdy;
    bit chk_drdy;
    bit iv;
    int op, s1, s2, d;
  } rec_t;

  rec_t   rec_q[$];
  entry_t ent_q[$];     // held instructions, oldest first
  entry_t out_e;        // instruction in the output register (valid = issue_valid)
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;

  task automatic chk(input string name, input int c, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, c, got, exp);
    end
  endtask

  // Monitor: compares the DUT against the expected record of the current cycle
  always @(negedge clk) begin
    rec_t r;
    if (rec_q.size() > 0) begin
      r = rec_q.pop_front();
      chk("occupancy", r.cyc, int'(occupancy), r.occ);
      if (r.chk_drdy) chk("disp_ready", r.cyc, int'(disp_ready), int'(r.drdy));
      chk("issue_valid", r.cyc, int'(issue_valid), int'(r.iv));
      chk("issue_opcode", r.cyc, int'(issue_opcode), r.op);
      chk("issue_src1", r.cyc, int'(issue_src1_prf), r.s1);
      chk("issue_src2", r.cyc, int'(issue_src2_prf), r.s2);
      chk("issue_dest", r.cyc, int'(issue_dest_prf), r.d);
    end
  end

  // ---------------- reference model ----------------
  function automatic bit hit(input logic [5:0] t);
    return cdb_valid && (cdb_tag == t);
  endfunction

  function automatic bit ready_now(input entry_t e);
    return (e.src1_rdy || hit(e.src1_prf)) && (e.src2_rdy || hit(e.src2_prf));
  endfunction

  task automatic model_step();
    int     sel;
    int     occ0;
    bit     load;
    entry_t e;
    if (flush) begin
      ent_q.delete();
      out_e = '0;
      return;
    end
    occ0 = ent_q.size();
    load = !out_e.valid || issue_ready;
    sel  = -1;
    if (load) begin
      foreach (ent_q[i]) if (sel < 0 && ready_now(ent_q[i])) sel = i;
    end
    foreach (ent_q[i]) begin
      if (hit(ent_q[i].src1_prf)) ent_q[i].src1_rdy = 1'b1;
      if (hit(ent_q[i].src2_prf)) ent_q[i].src2_rdy = 1'b1;
    end
    if (load) begin
      if (sel >= 0) begin
        out_e = ent_q[sel];
        out_e.valid = 1'b1;
        ent_q.delete(sel);
      end else begin
        out_e = '0;
      end
    end
    if (disp_valid && occ0 < DEPTH) begin
      e.valid    = 1'b1;
      e.opcode   = disp_opcode;
      e.src1_prf = disp_src1_prf;
      e.src2_prf = disp_src2_prf;
      e.dest_prf = disp_dest_prf;
      e.src1_rdy = disp_src1_ready || hit(disp_src1_prf);
      e.src2_rdy = disp_src2_ready || hit(disp_src2_prf);
      ent_q.push_back(e);
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic idle();
    disp_valid  = 1'b0;
    cdb_valid   = 1'b0;
    flush       = 1'b0;
    issue_ready = 1'b1;
  endtask

  task automatic disp(input int op, input int s1, input int s2, input int d,
                      input bit r1, input bit r2);
    disp_valid      = 1'b1;
    disp_opcode     = 5'(op);
    disp_src1_prf   = 6'(s1);
    disp_src2_prf   = 6'(s2);
    disp_dest_prf   = 6'(d);
    disp_src1_ready = r1;
    disp_src2_ready = r2;
  endtask

  task automatic cdb(input int t);
    cdb_valid = 1'b1;
    cdb_tag   = 6'(t);
  endtask

  // Inputs for the current cycle are already applied (posedge + 1).
  task automatic step(input bit do_rst);
    rec_t r;
    if (do_rst) begin
      #1 reset = 1'b0;
      ent_q.delete();
      out_e = '0;
    end else begin
      reset = 1'b1;
    end
    r.cyc = cyc; r.occ = ent_q.size(); r.drdy = (ent_q.size() < DEPTH);
    r.chk_drdy = !do_rst; r.iv = out_e.valid;
    r.op = int'(out_e.opcode); r.s1 = int'(out_e.src1_prf);
    r.s2 = int'(out_e.src2_prf); r.d = int'(out_e.dest_prf);
    rec_q.push_back(r);
    if (!do_rst) model_step();
    @(posedge clk);
    #1;
    cyc++;
    idle();
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step(1'b0);
  endtask

  initial begin
    out_e = '0;
    @(posedge clk);
    #1;
    idle();
    step(1'b1);
    step(1'b1);

    // Single ready instruction: visible after two edges
    disp(3, 5, 9, 12, 1, 1); step(1'b0);
    steps(3);

    // Older instruction waiting on tag 9 is overtaken, then woken by bypass
    disp(1, 1, 9, 20, 1, 0); step(1'b0);
    disp(2, 2, 3, 21, 1, 1); step(1'b0);
    step(1'b0);
    cdb(9); step(1'b0);
    steps(3);

    // Back-pressure: three ready entries, consumer stalled four cycles
    disp(4, 1, 2, 30, 1, 1); issue_ready = 1'b0; step(1'b0);
    disp(5, 1, 2, 31, 1, 1); issue_ready = 1'b0; step(1'b0);
    disp(6, 1, 2, 32, 1, 1); issue_ready = 1'b0; step(1'b0);
    for (int k = 0; k < 4; k++) begin issue_ready = 1'b0; step(1'b0); end
    steps(5);

    // Dispatch-time bypass of source 1
    disp(7, 7, 8, 40, 0, 1); cdb(7); step(1'b0);
    steps(3);

    // Fill all entries with waiting instructions, overflow, then free one
    for (int k = 0; k < DEPTH; k++) begin disp(8 + k, 32 + k, 32 + k, k, 0, 0); step(1'b0); end
    disp(31, 1, 1, 63, 1, 1); step(1'b0);
    cdb(35); step(1'b0);
    steps(3);

    // Flush with five held entries and one presented instruction
    flush = 1'b1; step(1'b0);
    for (int k = 0; k < 6; k++) begin disp(k, 0, 0, 50 + k, 1, 1); issue_ready = 1'b0; step(1'b0); end
    issue_ready = 1'b0; step(1'b0);
    flush = 1'b1; issue_ready = 1'b0; step(1'b0);
    steps(4);

    // Randomized traffic with occasional flush and one asynchronous reset
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 1) == 0) begin
        disp($urandom_range(0, 31), $urandom_range(0, 7), $urandom_range(0, 7),
             $urandom_range(0, 63), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 9) < 4) cdb($urandom_range(0, 7));
      issue_ready = ($urandom_range(0, 9) < 7);
      flush = ($urandom_range(0, 63) == 0);
      step(n == 700);
    end
    steps(3);

    @(negedge clk);
    #1;
    chk("records_drained", cyc, rec_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
